// File: rtl/instr_loader.sv
// Byte-to-instruction front end: packs three program bytes (MSB first) into a
// 24-bit word and hands it to the processor, tracking session count and errors.
module instr_loader #(
    parameter int          MEM_DEPTH      = 128,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  HALT_OPCODE    = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_in_valid,
    output logic                         byte_in_ready,
    output logic [23:0]                  instr_out,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [$clog2(MEM_DEPTH):0]   instr_count,
    output logic                         busy,
    output logic                         load_done,
    output logic                         overflow_err,
    output logic                         timeout_err
);

    localparam int CW = $clog2(MEM_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CW-1:0] MEM_MAX  = CW'(MEM_DEPTH);
    localparam logic [CW-1:0] MEM_LAST = CW'(MEM_DEPTH - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT,
        HOLD,
        DONE,
        ERROR
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [23:0]    instr_q, instr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;
    logic           tmo_q, tmo_d;
    logic [TW-1:0]  timer_q, timer_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= 2'd0;
            instr_q <= 24'd0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            instr_q <= instr_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            timer_q <= timer_d;
        end
    end

    // The idle timer defaults to zero, so it only advances on idle COLLECT
    // cycles with a partial word; any accepted byte restarts it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        instr_d = instr_q;
        count_d = count_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        tmo_d   = 1'b0;
        timer_d = '0;

        if (clear) begin
            state_d = COLLECT;
            idx_d   = 2'd0;
            instr_d = 24'd0;
            count_d = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (byte_in_valid) begin
                        case (idx_q)
                            2'd0:    instr_d[23:16] = byte_in;
                            2'd1:    instr_d[15:8]  = byte_in;
                            default: instr_d[7:0]   = byte_in;
                        endcase
                        if (idx_q == 2'd2) begin
                            idx_d   = 2'd0;
                            state_d = HOLD;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else if (idx_q != 2'd0) begin
                        if (timer_q == TMO_LAST) begin
                            idx_d   = 2'd0;
                            instr_d = 24'd0;
                            tmo_d   = 1'b1;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        if (count_q != MEM_MAX) begin
                            count_d = count_q + CW'(1);
                        end
                        // HALT wins even in the last slot; otherwise a full
                        // memory leaves no room for HALT and the load fails.
                        if (instr_q[23:16] == HALT_OPCODE) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (count_q == MEM_LAST) begin
                            state_d = ERROR;
                            ovf_d   = 1'b1;
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Ready is gated by rst_n so the source sees no acceptance during reset.
    always_comb begin
        byte_in_ready = rst_n && (state_q == COLLECT);
        instr_valid   = (state_q == HOLD);
        busy          = (idx_q != 2'd0) || (state_q == HOLD);
        instr_out     = instr_q;
        instr_count   = count_q;
        load_done     = done_q;
        overflow_err  = ovf_q;
        timeout_err   = tmo_q;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Front-end stage that sits directly upstream of the microprocessor's instruction-input port.
- Receives program bytes from a byte source (UART RX or keypad encoder) over a valid/ready handshake.
- Assembles 3 bytes, MSB first, into one 24-bit instruction: opcode[23:16], operand A[15:8], operand B[7:0].
- Hands each instruction downstream over a valid/ready handshake, counts instructions and tracks program-memory capacity.
- Ends the load on the HALT opcode; flags overflow and inter-byte timeouts.

Parameters:
- MEM_DEPTH, 128: downstream program-memory depth in words.
- TIMEOUT_CYCLES, 1000000: idle cycles allowed between bytes of a partial instruction.
- HALT_OPCODE, 8'h00: opcode that terminates the load.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous restart of a load session
- byte_in  in  8  incoming program byte
- byte_in_valid  in  1  byte_in holds a byte
- byte_in_ready  out  1  loader accepts a byte this cycle
- instr_out  out  24  assembled instruction
- instr_valid  out  1  instr_out holds an instruction
- instr_ready  in  1  downstream accepts instr_out
- instr_count  out  $clog2(MEM_DEPTH)+1  instructions transferred this session
- busy  out  1  partial instruction held, or instruction awaiting transfer
- load_done  out  1  HALT instruction transferred (sticky)
- overflow_err  out  1  memory filled without HALT (sticky)
- timeout_err  out  1  one-cycle pulse: partial instruction discarded

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous active-low (rst_n).
- Reset values: state=COLLECT, byte_idx=0, instr_out=0, instr_valid=0, instr_count=0, load_done=0, overflow_err=0, timeout_err=0, busy=0, timeout counter=0. byte_in_ready=0 while rst_n is low.
- States: COLLECT, HOLD, DONE, ERROR.
- byte_in_ready = (state==COLLECT). instr_valid = (state==HOLD).
- Byte handshake: a byte transfers on any edge where byte_in_valid and byte_in_ready are both high.
  - byte_idx 0 -> instr_out[23:16], idx 1 -> [15:8], idx 2 -> [7:0].
  - byte_idx increments 0->1->2. On the idx-2 accept, byte_idx returns to 0 and state goes to HOLD.
- Latency: third byte accepted at edge N -> instr_valid high from edge N through the instruction transfer. Throughput is at most one instruction per 4 cycles.
- HOLD: instr_out stays stable and no bytes are accepted. The instruction transfers on an edge where instr_valid and instr_ready are both high.
- On that transfer, instr_count increments (saturates at MEM_DEPTH), then:
  - opcode==HALT_OPCODE -> DONE, load_done=1.
  - else if instr_count before increment == MEM_DEPTH-1 -> ERROR, overflow_err=1. No slot is left for HALT.
  - else -> COLLECT.
- DONE and ERROR: byte_in_ready=0 and instr_valid=0. Only clear or reset leaves these states.
- Timeout: counter runs only while state==COLLECT and byte_idx!=0. It resets to 0 on every accepted byte and is held at 0 otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no byte accepted that cycle: byte_idx=0, instr_out=0, counter=0, timeout_err pulses high for exactly one cycle, state stays COLLECT.
  - A byte accepted on the same edge as expiry wins: it is taken and no timeout occurs.
- clear (synchronous, highest priority): the next state is COLLECT with byte_idx, instr_out, instr_count, load_done, overflow_err and counter all zeroed.
  - A byte or instruction handshake coinciding with clear is discarded and not counted.
- busy = (byte_idx!=0) or (state==HOLD).
- Reset mid-instruction discards all partial bytes immediately (async).

Test Plan:
- Bytes 02,01,05 back-to-back, instr_ready=1 -> instr_out=0x020105, instr_valid for 1 cycle, instr_count=1, back in COLLECT with byte_in_ready=1.
- Bytes 06,00,01, then 00,00,00; instr_ready held 0 for 5 cycles on the first word -> instr_out stable 0x060001 and byte_in_ready=0 throughout. Then HALT transfers, load_done=1, instr_count=2, byte_in_ready stays 0.
- Generics TIMEOUT_CYCLES=16, MEM_DEPTH=4: send bytes 08,03 then idle 16 cycles -> timeout_err single pulse, busy=0. Next bytes 08,03,00 -> instr_out=0x080300.
- MEM_DEPTH=4: four non-HALT instructions -> overflow_err=1 after the 4th transfer, instr_count=4, byte_in_ready=0. Then clear -> instr_count=0, flags 0, byte_in_ready=1.
- Assert clear coincident with the 3rd byte of 0E,00,03 -> byte dropped, instr_valid never rises, byte_idx=0.
- Assert rst_n low asynchronously mid-HOLD (no clock edge) -> instr_valid and instr_out drop to 0 immediately; after release, byte_in_ready=1.
